psram_responder: RTL

PSRAM_RESPONDER -- requirements
Module: psram_responder

---
 rtl/psram_responder.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/psram_responder.sv
// Octal PSRAM target model: oversamples the initiator's csn/sclk/data with clk_i,
// decodes a read/write command plus 24-bit address and serves bytes from a local memory.
module psram_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 4
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       i_psram_csn,
    input  logic       i_psram_sclk,
    input  logic [7:0] i_psram_data,
    output logic [7:0] o_psram_data,
    output logic       o_psram_oe,
    output logic [2:0] o_state,
    output logic       o_cmd_err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CMD   = 3'd1,
        S_ADDR  = 3'd2,
        S_DUMMY = 3'd3,
        S_RDATA = 3'd4,
        S_WDATA = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_READ  = 8'h03;

    state_t      state_q, state_d;
    logic        csn_s1, csn_s2;
    logic        sclk_s1, sclk_s2, sclk_prev;
    logic [7:0]  data_s1, data_s2;
    logic        rise, fall;
    logic [23:0] addr_q;
    logic [1:0]  addr_cnt_q;
    logic [15:0] dummy_cnt_q;
    logic        dummy_last;
    logic        is_read_q;
    logic [7:0]  rdata_q;
    logic        cmd_err_q;
    logic        cmd_valid;
    logic        mem_we;
    logic [7:0]  mem [0:(1<<ADDR_W)-1];

    // Data shares the sclk synchronizer depth, so a byte set up before the
    // sclk edge at the pins is stable in data_s2 on the detected edge.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            csn_s1    <= 1'b1;
            csn_s2    <= 1'b1;
            sclk_s1   <= 1'b0;
            sclk_s2   <= 1'b0;
            sclk_prev <= 1'b0;
            data_s1   <= 8'h00;
            data_s2   <= 8'h00;
        end else begin
            csn_s1    <= i_psram_csn;
            csn_s2    <= csn_s1;
            sclk_s1   <= i_psram_sclk;
            sclk_s2   <= sclk_s1;
            sclk_prev <= sclk_s2;
            data_s1   <= i_psram_data;
            data_s2   <= data_s1;
        end
    end

    assign rise       = ~sclk_prev & sclk_s2;
    assign fall       = sclk_prev & ~sclk_s2;
    assign cmd_valid  = (data_s2 == CMD_WRITE) || (data_s2 == CMD_READ);
    assign dummy_last = (int'(dummy_cnt_q) + 1) >= LATENCY;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Deselect takes priority over any sclk edge seen in the same cycle.
    always_comb begin
        state_d = state_q;
        if (csn_s2) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  state_d = S_CMD;
                S_CMD:   if (rise) state_d = cmd_valid ? S_ADDR : S_ERR;
                S_ADDR: begin
                    if (rise && addr_cnt_q == 2'd2) begin
                        if (is_read_q) state_d = (LATENCY == 0) ? S_RDATA : S_DUMMY;
                        else           state_d = S_WDATA;
                    end
                end
                S_DUMMY: if (rise && dummy_last) state_d = S_RDATA;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            addr_q      <= 24'h000000;
            addr_cnt_q  <= 2'd0;
            dummy_cnt_q <= 16'd0;
            is_read_q   <= 1'b0;
            rdata_q     <= 8'h00;
            cmd_err_q   <= 1'b0;
        end else if (csn_s2) begin
            addr_cnt_q  <= 2'd0;
            dummy_cnt_q <= 16'd0;
            rdata_q     <= 8'h00;
        end else begin
            case (state_q)
                S_CMD: begin
                    if (rise) begin
                        is_read_q  <= (data_s2 == CMD_READ);
                        addr_cnt_q <= 2'd0;
                        if (!cmd_valid) cmd_err_q <= 1'b1;
                    end
                end
                S_ADDR: begin
                    if (rise) begin
                        addr_q      <= {addr_q[15:0], data_s2};
                        addr_cnt_q  <= addr_cnt_q + 2'd1;
                        dummy_cnt_q <= 16'd0;
                    end
                end
                S_DUMMY: if (rise) dummy_cnt_q <= dummy_cnt_q + 16'd1;
                S_RDATA: begin
                    if (fall) begin
                        rdata_q <= mem[addr_q[ADDR_W-1:0]];
                        addr_q  <= addr_q + 24'd1;
                    end
                end
                S_WDATA: if (rise) addr_q <= addr_q + 24'd1;
                default: ;
            endcase
        end
    end

    // Memory has no reset so its contents survive rstn_i.
    assign mem_we = (state_q == S_WDATA) && rise && !csn_s2;

    always_ff @(posedge clk_i) begin
        if (mem_we) mem[addr_q[ADDR_W-1:0]] <= data_s2;
    end

    assign o_psram_oe   = (state_q == S_RDATA);
    assign o_psram_data = o_psram_oe ? rdata_q : 8'h00;
    assign o_state      = state_q;
    assign o_cmd_err    = cmd_err_q;

endmodule
